// File: rtl/qunion_pkg.sv
// Shared definitions for the two-input queue multiplexer: source tags and the
// end-of-transaction test.
package qunion_pkg;

  localparam logic CTRL_DIN0 = 1'b0;
  localparam logic CTRL_DIN1 = 1'b1;

  // Widest eot field supported; callers pad unused upper bits with ones.
  localparam int EOT_MAX = 8;

  function automatic logic eot_done(input logic [EOT_MAX-1:0] eot);
    return &eot;
  endfunction

endpackage

// File: rtl/qunion_mux_arb.sv
// Transaction-granular arbiter: holds the lock owner until its eot beat is
// accepted and round-robins between inputs at transaction boundaries.
module qunion_mux_arb
  import qunion_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_load_en,
  input  logic i_eot_done,
  output logic o_sel,
  output logic o_grant,
  output logic o_locked,
  output logic o_lock_sel,
  output logic o_last_grant
);

  logic r_locked;
  logic r_lock_sel;
  logic r_last_grant;
  logic w_sel;
  logic w_grant;

  always_comb begin
    w_sel   = CTRL_DIN0;
    w_grant = 1'b0;
    if (r_locked) begin
      w_sel   = r_lock_sel;
      w_grant = r_lock_sel ? i_valid1 : i_valid0;
    end else if (i_valid0 && i_valid1) begin
      w_sel   = ~r_last_grant;
      w_grant = 1'b1;
    end else if (i_valid1) begin
      w_sel   = CTRL_DIN1;
      w_grant = 1'b1;
    end else if (i_valid0) begin
      w_sel   = CTRL_DIN0;
      w_grant = 1'b1;
    end
  end

  // last_grant resets to din1 so that din0 wins the first contended grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked     <= 1'b0;
      r_lock_sel   <= CTRL_DIN0;
      r_last_grant <= CTRL_DIN1;
    end else if (w_grant && i_load_en) begin
      if (i_eot_done) begin
        r_locked     <= 1'b0;
        r_last_grant <= w_sel;
      end else begin
        r_locked     <= 1'b1;
        r_lock_sel   <= w_sel;
      end
    end
  end

  assign o_sel        = w_sel;
  assign o_grant      = w_grant;
  assign o_locked     = r_locked;
  assign o_lock_sel   = r_lock_sel;
  assign o_last_grant = r_last_grant;

endmodule

// File: rtl/qunion_mux.sv
// Two-input queue multiplexer producing a tagged-union stream {eot, ctrl, data}
// through a single registered output stage.
module qunion_mux
  import qunion_pkg::*;
#(
  parameter int W_DIN0 = 16,
  parameter int W_DIN1 = 16,
  parameter int W_DOUT = 16,
  parameter int LVL    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_din0_valid,
  input  logic [LVL+W_DIN0-1:0]   i_din0_data,
  output logic                    o_din0_ready,
  input  logic                    i_din1_valid,
  input  logic [LVL+W_DIN1-1:0]   i_din1_data,
  output logic                    o_din1_ready,
  output logic                    o_dout_valid,
  output logic [LVL+1+W_DOUT-1:0] o_dout_data,
  input  logic                    i_dout_ready,
  output logic                    o_dbg_locked,
  output logic                    o_dbg_lock_sel,
  output logic                    o_dbg_last_grant
);

  // Handshake: a beat moves when valid && ready at a rising edge; valid never
  // waits on ready, and a held beat keeps its data stable until taken.

  if (W_DOUT < W_DIN0 || W_DOUT < W_DIN1) begin : g_bad_width
    $error("qunion_mux: W_DOUT must be >= both input data widths");
  end
  if (LVL < 1 || LVL > EOT_MAX) begin : g_bad_lvl
    $error("qunion_mux: LVL out of supported range");
  end

  typedef struct packed {
    logic [LVL-1:0]    eot;
    logic              ctrl;
    logic [W_DOUT-1:0] data;
  } dout_t;

  dout_t              r_dout;
  logic               r_full;
  logic               w_sel;
  logic               w_grant;
  logic               w_load_en;
  logic               w_hs;
  logic               w_eot_done;
  logic [LVL-1:0]     w_sel_eot;
  logic [W_DOUT-1:0]  w_sel_data;
  logic [EOT_MAX-1:0] w_eot_pad;

  always_comb begin
    w_sel_data = '0;
    if (w_sel == CTRL_DIN1) begin
      w_sel_eot                  = i_din1_data[LVL+W_DIN1-1 -: LVL];
      w_sel_data[W_DIN1-1:0]     = i_din1_data[W_DIN1-1:0];
    end else begin
      w_sel_eot                  = i_din0_data[LVL+W_DIN0-1 -: LVL];
      w_sel_data[W_DIN0-1:0]     = i_din0_data[W_DIN0-1:0];
    end
    w_eot_pad          = '1;
    w_eot_pad[LVL-1:0] = w_sel_eot;
  end

  assign w_eot_done = eot_done(w_eot_pad);
  assign w_load_en  = !r_full || (r_full && i_dout_ready);
  // Readies are forced low while reset is held so no beat is taken in reset.
  assign w_hs       = rst && w_load_en && w_grant;

  qunion_mux_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_valid0     (i_din0_valid),
    .i_valid1     (i_din1_valid),
    .i_load_en    (rst && w_load_en),
    .i_eot_done   (w_eot_done),
    .o_sel        (w_sel),
    .o_grant      (w_grant),
    .o_locked     (o_dbg_locked),
    .o_lock_sel   (o_dbg_lock_sel),
    .o_last_grant (o_dbg_last_grant)
  );

  assign o_din0_ready = w_hs && i_din0_valid && (w_sel == CTRL_DIN0);
  assign o_din1_ready = w_hs && i_din1_valid && (w_sel == CTRL_DIN1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_dout <= '0;
    end else if (w_hs) begin
      r_full      <= 1'b1;
      r_dout.eot  <= w_sel_eot;
      r_dout.ctrl <= w_sel;
      r_dout.data <= w_sel_data;
    end else if (r_full && i_dout_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_dout_valid = r_full;
  assign o_dout_data  = r_dout;

endmodule

// File: tb/tb_qunion_mux.sv
// Directed bench for qunion_mux: W_DIN0=8, W_DIN1=4, W_DOUT=16, LVL=1.
module tb_qunion_mux;

  localparam int W_OUT = 18;

  logic             clk;
  logic             rst;
  logic             i_din0_valid;
  logic [8:0]       i_din0_data;
  logic             o_din0_ready;
  logic             i_din1_valid;
  logic [4:0]       i_din1_data;
  logic             o_din1_ready;
  logic             o_dout_valid;
  logic [W_OUT-1:0] o_dout_data;
  logic             i_dout_ready;
  logic             o_dbg_locked;
  logic             o_dbg_lock_sel;
  logic             o_dbg_last_grant;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  int cyc     = 0;
  logic [W_OUT-1:0] exp_q[$];

  qunion_mux #(.W_DIN0(8), .W_DIN1(4), .W_DOUT(16), .LVL(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_din0_valid     (i_din0_valid),
    .i_din0_data      (i_din0_data),
    .o_din0_ready     (o_din0_ready),
    .i_din1_valid     (i_din1_valid),
    .i_din1_data      (i_din1_data),
    .o_din1_ready     (o_din1_ready),
    .o_dout_valid     (o_dout_valid),
    .o_dout_data      (o_dout_data),
    .i_dout_ready     (i_dout_ready),
    .o_dbg_locked     (o_dbg_locked),
    .o_dbg_lock_sel   (o_dbg_lock_sel),
    .o_dbg_last_grant (o_dbg_last_grant)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W_OUT-1:0] mk(input logic e, input logic c, input logic [15:0] d);
    return {e, c, d};
  endfunction

  task automatic push(input logic [W_OUT-1:0] v);
    exp_q.push_back(v);
    n_push++;
  endtask

  // Driver tasks: called on a falling edge, return on the falling edge after acceptance.
  task automatic send0(input logic [7:0] d, input logic e);
    logic acc;
    acc = 1'b0;
    i_din0_valid = 1'b1;
    i_din0_data  = {e, d};
    for (int n = 0; n < 100 && !acc; n++) begin
      #4;
      acc = o_din0_ready;
      @(negedge clk);
    end
    i_din0_valid = 1'b0;
    if (!acc) check("timeout0", 32'd0, 32'd1);
    else      check("lat0", o_dout_data, mk(e, 1'b0, {8'h00, d}));
  endtask

  task automatic send1(input logic [3:0] d, input logic e);
    logic acc;
    acc = 1'b0;
    i_din1_valid = 1'b1;
    i_din1_data  = {e, d};
    for (int n = 0; n < 100 && !acc; n++) begin
      #4;
      acc = o_din1_ready;
      @(negedge clk);
    end
    i_din1_valid = 1'b0;
    if (!acc) check("timeout1", 32'd0, 32'd1);
    else      check("lat1", o_dout_data, mk(e, 1'b1, {12'h000, d}));
  endtask

  // Scoreboard: every output handshake must match the head of exp_q.
  initial begin
    logic [W_OUT-1:0] exp;
    forever begin
      @(negedge clk);
      #4;
      if (o_dout_valid && i_dout_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", 32'd0, 32'd1);
        end else begin
          exp = exp_q.pop_front();
          n_pop++;
          check("sb_data", o_dout_data, exp);
        end
      end
    end
  end

  initial begin
    int c0;
    rst          = 1'b0;
    i_dout_ready = 1'b1;
    i_din0_valid = 1'b1;
    i_din0_data  = 9'h05A;
    i_din1_valid = 1'b1;
    i_din1_data  = 5'h03;

    // 1: reset holds everything idle even with both inputs valid
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", o_dout_valid, 0);
    check("rst_rdy0", o_din0_ready, 0);
    check("rst_rdy1", o_din1_ready, 0);
    check("rst_data", o_dout_data, 0);
    check("rst_last", o_dbg_last_grant, 1);
    rst = 1'b1;
    #1;
    check("first_rdy0", o_din0_ready, 1);
    check("first_rdy1", o_din1_ready, 0);
    i_din0_valid = 1'b0;
    i_din1_valid = 1'b0;
    @(negedge clk);

    // 2: single source, three-beat transaction
    push(mk(1'b0, 1'b0, 16'h0011));
    push(mk(1'b0, 1'b0, 16'h0022));
    push(mk(1'b1, 1'b0, 16'h0033));
    c0 = cyc;
    send0(8'h11, 1'b0);
    check("t2_locked", o_dbg_locked, 1);
    send0(8'h22, 1'b0);
    send0(8'h33, 1'b1);
    check("t2_cycles", cyc - c0, 3);
    check("t2_unlock", o_dbg_locked, 0);
    check("t2_last", o_dbg_last_grant, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 3: contention, whole transactions never interleave
    push(mk(1'b0, 1'b0, 16'h00A1));
    push(mk(1'b0, 1'b0, 16'h00A2));
    push(mk(1'b1, 1'b0, 16'h00A3));
    push(mk(1'b0, 1'b1, 16'h0001));
    push(mk(1'b1, 1'b1, 16'h0002));
    push(mk(1'b1, 1'b0, 16'h00A4));
    c0 = cyc;
    fork
      begin
        send0(8'hA1, 1'b0);
        send0(8'hA2, 1'b0);
        send0(8'hA3, 1'b1);
        send0(8'hA4, 1'b1);
      end
      begin
        send1(4'h1, 1'b0);
        send1(4'h2, 1'b1);
      end
    join
    check("t3_cycles", cyc - c0, 6);
    @(negedge clk);

    // 4: backpressure holds data and stalls both inputs
    i_dout_ready = 1'b0;
    push(mk(1'b1, 1'b0, 16'h0061));
    send0(8'h61, 1'b1);
    i_din0_valid = 1'b1;
    i_din0_data  = 9'h162;
    i_din1_valid = 1'b1;
    i_din1_data  = 5'h18;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rdy0", o_din0_ready, 0);
      check("bp_rdy1", o_din1_ready, 0);
      check("bp_valid", o_dout_valid, 1);
      check("bp_data", o_dout_data, mk(1'b1, 1'b0, 16'h0061));
      @(negedge clk);
    end
    i_dout_ready = 1'b1;
    push(mk(1'b1, 1'b1, 16'h0008));
    push(mk(1'b1, 1'b0, 16'h0062));
    fork
      send0(8'h62, 1'b1);
      send1(4'h8, 1'b1);
    join
    @(negedge clk);

    // 5: lock hold while the owner idles
    push(mk(1'b0, 1'b0, 16'h0044));
    send0(8'h44, 1'b0);
    i_din1_valid = 1'b1;
    i_din1_data  = 5'h19;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lk_rdy1", o_din1_ready, 0);
      check("lk_locked", o_dbg_locked, 1);
      check("lk_sel", o_dbg_lock_sel, 0);
      if (i > 0) check("lk_idle", o_dout_valid, 0);
      @(negedge clk);
    end
    push(mk(1'b1, 1'b0, 16'h0055));
    push(mk(1'b1, 1'b1, 16'h0009));
    fork
      send0(8'h55, 1'b1);
      send1(4'h9, 1'b1);
    join
    @(negedge clk);

    // 6: narrow input zero-extension, then async reset mid-transaction
    push(mk(1'b1, 1'b1, 16'h000A));
    send1(4'hA, 1'b1);
    @(negedge clk);
    i_dout_ready = 1'b0;
    send1(4'h3, 1'b0);
    check("ar_locked", o_dbg_locked, 1);
    check("ar_valid", o_dout_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid_drop", o_dout_valid, 0);
    check("ar_unlock", o_dbg_locked, 0);
    check("ar_data", o_dout_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b1;
    i_din0_valid = 1'b1;
    i_din0_data  = 9'h077;
    i_din1_valid = 1'b1;
    i_din1_data  = 5'h04;
    #1;
    check("ar_rdy0", o_din0_ready, 1);
    check("ar_rdy1", o_din1_ready, 0);
    i_din0_valid = 1'b0;
    i_din1_valid = 1'b0;
    i_dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    check("sb_left", exp_q.size(), 0);
    check("sb_count", n_pop, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qunion_mux.md
Name: qunion_mux

Overview:
- Two-input queue multiplexer that feeds the queue field filter (qfilt) stage.
- Merges two queue streams into one tagged-union stream, format {eot[LVL-1:0], ctrl, data}; ctrl names the source input.
- Arbitrates at whole-transaction granularity, so the beats of different transactions never interleave.
- Single registered output stage: 1-cycle latency, full throughput.

Parameters:
- W_DIN0, 16, data width of din0 (excluding eot)
- W_DIN1, 16, data width of din1 (excluding eot)
- W_DOUT, 16, output data field width; must be >= max(W_DIN0, W_DIN1)
- LVL, 1, queue eot depth; must be >= 1

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- din0  dti.consumer  LVL+W_DIN0  queue input 0, data = {eot, data}
- din1  dti.consumer  LVL+W_DIN1  queue input 1, data = {eot, data}
- dout  dti.producer  LVL+1+W_DOUT  tagged output, data = {eot, ctrl, data}

Behaviour:
- Reset: one clock; rst asynchronous, active-low; all flops clear immediately on assertion.
  - Reset values: dout.valid=0, dout.data=0, din0.ready=0, din1.ready=0, locked=0, lock_sel=0, last_grant=1 (din0 has first priority).
- Transaction end: a beat whose eot bits are all ones (&eot), i.e. the end of the outermost level.
- Output register: reg_full flag plus data register.
  - load_en = !reg_full || (dout.valid && dout.ready).
  - dout.valid = reg_full.
  - Registered data holds stable while valid && !ready.
- Grant select (combinational):
  - locked: sel = lock_sel.
  - Unlocked, both inputs valid: sel = !last_grant.
  - Unlocked, one input valid: sel = that input.
  - Unlocked, neither valid: no grant.
- Ready: din_k.ready = load_en && din_k.valid && granted(k) && sel==k. The non-selected input's ready is 0.
  - Ready may depend on own valid; the input must not wait for ready before asserting valid.
- Load: on a din_sel handshake:
  - reg <= {din.eot, sel, zero-extend(din.data to W_DOUT)}, reg_full <= 1.
  - If !&eot: locked <= 1, lock_sel <= sel.
  - If &eot: locked <= 0, last_grant <= sel.
- Unload: dout handshake without a simultaneous load gives reg_full <= 0, register data unchanged.
- Simultaneous unload and load: register overwritten, reg_full stays 1; one beat per cycle sustained.
- Locked while the owner is not valid: output drains and then idles. The other input stays stalled (ready=0) even if valid, until the owner's eot beat is accepted.
- Single-beat transactions (&eot on first beat): never lock; round-robin alternates per transaction when both inputs are busy.
- Reset mid-transaction: the partial transaction is discarded. After release, arbitration restarts unlocked with din0 priority. Upstream must restart its transaction.
- Width rule: data is zero-extended. W_DOUT below max input width is an elaboration error (assertion).
- No combinational path from dout.ready to dout.valid or dout.data. A combinational path from dout.ready to din*.ready exists via load_en.

Decomposition:
- Shared package qunion_pkg:
  - ctrl encodings CTRL_DIN0=1'b0, CTRL_DIN1=1'b1.
  - Function eot_done(eot) returning &eot.
- Packed struct typedefs stay local to the module, since they are width-parameterised.
- One sub-module: qunion_mux_arb, holding the lock/round-robin state and the grant logic.
  - Inputs: valid0, valid1, load_en, eot_done.
  - Outputs: sel, grant.
- The output register is inline.

Test Plan:
1. Reset: hold rst=0 with both inputs valid -> dout.valid=0, din0.ready=din1.ready=0. Release -> first grant goes to din0.
2. Single source: LVL=1, W=8, din0 sends 0x11,0x22,0x33 (eot on 0x33), dout.ready=1 -> dout shows {0,0,0x11},{0,0,0x22},{1,0,0x33} on consecutive cycles, 1 cycle after each accept.
3. Contention: both inputs valid from cycle 0. din0 sends 3-beat txn A1..A3, din1 sends 2-beat txn B1,B2 -> output A1,A2,A3,B1,B2 with no gap. din1.ready=0 until A3 is accepted. A next din0 txn waits until B2 is accepted.
4. Backpressure: register full, dout.ready=0 for 5 cycles -> dout.data stable, both readies 0. Ready=1 -> stream resumes with no beat lost or duplicated (scoreboard count equal).
5. Lock hold: din0 sends 0x44 (eot=0), then valid=0 for 4 cycles while din1 is valid -> din1.ready stays 0, dout idle after the drain. din0 sends 0x55 eot=1 -> din1 granted on the next load.
6. Width/async reset: W_DIN1=4, din1 sends 0xA eot=1 -> dout {1,1,0x000A}. Assert rst mid-clock during a locked txn -> dout.valid falls before the next edge, lock cleared.
